// File: rtl/adj_fmwm_aggregator.sv
// Sparsity-aware GCN aggregation: one output row of ADJ x (FM*WM) per transaction.
// Fetches only the FM*WM rows selected by the adjacency mask and sums all channels in parallel.
module adj_fmwm_aggregator #(
    parameter int NUM_OF_NODES   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter bit SATURATE       = 1'b1,
    parameter bit ADD_SELF_LOOP  = 1'b0,
    localparam int ROW_W = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1,
    localparam int DW    = WEIGHT_COLS * DOT_PROD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROW_W-1:0]        in_row,
    input  logic [NUM_OF_NODES-1:0] adj_row,
    output logic                    fm_rd_en,
    output logic [ROW_W-1:0]        fm_rd_addr,
    input  logic [DW-1:0]           fm_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROW_W-1:0]        out_row,
    output logic [DW-1:0]           out_data,
    output logic [ROW_W:0]          out_nnz,
    output logic                    out_sat,
    output logic                    busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and offered data is held until the transfer.

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t                  state, state_nxt;
    logic [NUM_OF_NODES-1:0] mask;
    logic [NUM_OF_NODES-1:0] mask_rest;
    logic [NUM_OF_NODES-1:0] self_bit;
    logic [NUM_OF_NODES-1:0] eff_mask;
    logic [ROW_W-1:0]        lowest_idx;
    logic                    lowest_found;
    logic                    pending;
    logic                    accept;
    logic [DW-1:0]           acc_nxt;
    logic                    sat_nxt;
    logic [DOT_PROD_WIDTH:0] ch_sum [WEIGHT_COLS];

    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign eff_mask  = adj_row | self_bit;
    assign mask_rest = mask & (mask - 1'b1);

    always_comb begin
        for (int j = 0; j < NUM_OF_NODES; j++) begin
            self_bit[j] = ADD_SELF_LOOP && (in_row == ROW_W'(j));
        end
    end

    always_comb begin
        lowest_idx   = '0;
        lowest_found = 1'b0;
        for (int j = 0; j < NUM_OF_NODES; j++) begin
            if (!lowest_found && mask[j]) begin
                lowest_idx   = ROW_W'(j);
                lowest_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        fm_rd_en   = 1'b0;
        fm_rd_addr = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (eff_mask != '0) ? ISSUE : OUT;
            end
            ISSUE: begin
                fm_rd_en   = 1'b1;
                fm_rd_addr = lowest_idx;
                if (mask_rest == '0) state_nxt = WAIT;
            end
            WAIT:    state_nxt = OUT;
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Carry out of the widened add flags overflow; a clamped channel stays at max
    // because any further addend carries again.
    always_comb begin
        acc_nxt = out_data;
        sat_nxt = out_sat;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            ch_sum[c] = {1'b0, out_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]}
                      + {1'b0, fm_rd_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]};
            if (ch_sum[c][DOT_PROD_WIDTH]) begin
                sat_nxt = 1'b1;
                acc_nxt[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] =
                    SATURATE ? {DOT_PROD_WIDTH{1'b1}} : ch_sum[c][DOT_PROD_WIDTH-1:0];
            end else begin
                acc_nxt[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = ch_sum[c][DOT_PROD_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mask     <= '0;
            pending  <= 1'b0;
            out_row  <= '0;
            out_data <= '0;
            out_nnz  <= '0;
            out_sat  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= fm_rd_en;
            if (accept) begin
                mask     <= eff_mask;
                out_row  <= in_row;
                out_data <= '0;
                out_nnz  <= '0;
                out_sat  <= 1'b0;
            end else begin
                if (fm_rd_en) mask <= mask_rest;
                if (pending) begin
                    out_data <= acc_nxt;
                    out_sat  <= sat_nxt;
                    out_nnz  <= out_nnz + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/adj_fmwm_aggregator.md
# adj_fmwm_aggregator

Streaming, sparsity-aware GCN aggregation engine that computes one output row of ADJ × (FM·WM) per transaction. It accepts an adjacency row over a valid/ready handshake, fetches only the FM·WM rows whose adjacency bit is set from an external one-cycle-latency read port, and accumulates all WEIGHT_COLS channels in parallel. The result is presented on a valid/ready output with per-row overflow status. It sits between the FM·WM product buffer and the layer output buffer.

## Interface
- NUM_OF_NODES, 6, graph node count; adjacency row width and FM·WM depth
- WEIGHT_COLS, 3, output channels per row
- DOT_PROD_WIDTH, 16, unsigned width of each FM·WM element and each result channel
- SATURATE, 1, 1 = clamp to 2^DOT_PROD_WIDTH−1 on overflow; 0 = wrap modulo 2^DOT_PROD_WIDTH
- ADD_SELF_LOOP, 0, 1 = treat adj_row[in_row] as set (A+I aggregation)
- Derived: ROW_W = $clog2(NUM_OF_NODES); channel c occupies bits [c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] of packed buses

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  adjacency row offered
- in_ready  out  1  block can accept a row
- in_row  in  ROW_W  row index; used for self-loop and echoed on out_row
- adj_row  in  NUM_OF_NODES  bit j = edge to node j
- fm_rd_en  out  1  read strobe to FM·WM buffer
- fm_rd_addr  out  ROW_W  FM·WM row address
- fm_rd_data  in  WEIGHT_COLS*DOT_PROD_WIDTH  packed row, valid the cycle after fm_rd_en
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_row  out  ROW_W  captured in_row
- out_data  out  WEIGHT_COLS*DOT_PROD_WIDTH  packed aggregated row
- out_nnz  out  ROW_W+1  number of rows accumulated
- out_sat  out  1  any channel overflowed during this row (sticky per row)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_row and adj_row (OR self bit when ADD_SELF_LOOP=1), clear accumulators, out_sat, and nnz. Next state ISSUE if the effective mask ≠ 0, else OUT.
- ISSUE: each cycle assert fm_rd_en with fm_rd_addr = lowest remaining set bit, then clear that bit. After the last set bit has been issued, go to WAIT.
- Pipeline: a registered "pending" flag marks that fm_rd_data is returning this cycle. Each returned row is added to all channels and nnz increments.
- WAIT: the final data beat accumulates, then go to OUT.
- OUT: out_valid=1 and outputs are held stable. On out_ready, go to IDLE.
- Arithmetic: each channel uses a DOT_PROD_WIDTH+1-bit add. On a carry, out_sat is set. With SATURATE=1 the channel is clamped and stays at max for the rest of the row. With SATURATE=0 the channel keeps the low DOT_PROD_WIDTH bits.
- fm_rd_data is ignored whenever pending=0.
- Reset (any time, including mid-row): state IDLE; in_ready=1 after release. All other outputs are 0: fm_rd_en, fm_rd_addr, out_valid, out_row, out_data, out_nnz, out_sat, busy. Pending is cleared, so in-flight read data is discarded.

## Timing
- Handshake edge T with k effective set bits:
  - fm_rd_en is high in cycles T+1 … T+k, addresses in ascending order.
  - out_valid rises at T+k+2.
  - For k=0, out_valid rises at T+1 with all-zero data and out_nnz=0.
- in_ready is low from T+1 until the cycle after the out handshake. There is no overlap between rows.
- out handshake at edge U: out_valid=0 and in_ready=1 at U+1. The earliest next accept is at edge U+1.
- out_ready held high before out_valid: the transfer completes in the first out_valid cycle.
- Full row (k=NUM_OF_NODES): total occupancy is NUM_OF_NODES+2 cycles plus out backpressure.

## Test plan
Default FM·WM rows used below: r0={11488,0,0}, r1={6684,0,0}, r2={7687,6093,0}, r3={7687,9853,8976}, r4={0,6684,8976}, r5={0,6093,6093}.

- Row 1, adj bits {0,2} set → reads addr 0 then 2; out_data={19175,6093,0}, out_nnz=2, out_sat=0, out_valid at T+4.
- Row 3, bits {2,4,5} → {7687,18870,15069}, nnz=3, reads 2,4,5 on consecutive cycles.
- ADD_SELF_LOOP=1, row 0, bit {1} → reads 0,1; out_data={18172,0,0}, nnz=2.
- adj_row=0, ADD_SELF_LOOP=0 → out_valid at T+1, out_data=0, nnz=0, fm_rd_en never asserted.
- Channel-0 values 40000 and 30000, two bits set:
  - SATURATE=1 → channel 0 = 65535, out_sat=1.
  - SATURATE=0 → channel 0 = 4464, out_sat=1.
- Hold out_ready low for 5 cycles: outputs stay stable and in_ready stays 0. Then assert reset mid-ISSUE on a new row: outputs are 0 immediately, late fm_rd_data is ignored, and the next row computes correctly.
